// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the unified-memory arbiter
package mem_arb_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA = 1'b1;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: loadable latency counter flagging the response cycle
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  output logic o_done
);
  logic [CNT_W-1:0] r_cnt;
  assign o_done = r_cnt == CNT_W'(LATENCY);
  // Load 1 on issue, count while running, park at 0 once the response cycle is reached
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else r_cnt <= i_start ? CNT_W'(1) : (o_done || r_cnt == '0) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-ported memory between fetch and data ports
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ready,
  output logic        o_if_valid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_wen,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_mask,
  output logic        o_d_ready,
  output logic        o_d_valid,
  output logic [31:0] o_d_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic [31:0] i_mem_rdata
);
  state_t r_state, w_next;
  logic r_owner, r_last, r_store;
  logic w_idle, w_gnt_if, w_gnt_d, w_resp, w_done;
  logic [31:0] w_addr;
  mem_arb_timer #(.LATENCY(LATENCY)) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_start(w_gnt_if || w_gnt_d),
    .o_done (w_done)
  );
  // Grant, issue-cycle memory drive, response routing and next state; reset silences every output
  always_comb begin
    w_idle = i_rst_n && r_state == ST_IDLE;
    w_gnt_d = w_idle && i_d_req && (!i_if_req || r_last == OWN_FETCH);
    w_gnt_if = w_idle && i_if_req && !w_gnt_d;
    w_resp = i_rst_n && r_state == ST_WAIT && w_done;
    w_addr = (w_gnt_d ? i_d_addr : i_if_addr) & 32'hFFFF_FFFC;
    o_if_ready = w_gnt_if;
    o_d_ready = w_gnt_d;
    o_mem_addr = (w_gnt_if || w_gnt_d) ? w_addr : '0;
    o_mem_ren = w_gnt_if || (w_gnt_d && !i_d_wen);
    o_mem_wen = w_gnt_d && i_d_wen;
    o_mem_wdata = w_gnt_d ? i_d_wdata : '0;
    o_mem_mask = w_gnt_if ? 4'hF : w_gnt_d ? i_d_mask : 4'h0;
    o_if_valid = w_resp && r_owner == OWN_FETCH;
    o_d_valid = w_resp && r_owner == OWN_DATA;
    o_if_rdata = o_if_valid ? i_mem_rdata : '0;
    o_d_rdata = (o_d_valid && !r_store) ? i_mem_rdata : '0;
    w_next = (r_state == ST_IDLE) ? ((w_gnt_if || w_gnt_d) ? ST_WAIT : ST_IDLE) : (w_done ? ST_IDLE : ST_WAIT);
  end
  // State register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  // Owner, store flag and round-robin history captured at issue
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_owner <= OWN_FETCH;
      r_last <= OWN_DATA;
      r_store <= 1'b0;
    end else if (w_gnt_if || w_gnt_d) begin
      r_owner <= w_gnt_d;
      r_last <= w_gnt_d;
      r_store <= w_gnt_d && i_d_wen;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table, directed and random checks of three arbiters (latency 2, 1, 15)
module tb_mem_arbiter;
  localparam int LATS[3] = '{2, 1, 15};
  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;
  typedef struct packed {
    logic ifr; logic ifv; logic [31:0] ifd;
    logic dr; logic dv; logic [31:0] dd;
    logic [31:0] ma; logic ren; logic wen; logic [31:0] wd; logic [3:0] mk;
  } out_t;
  typedef struct {
    bit rst; bit ifr; logic [31:0] ia; bit dr; bit dw; logic [31:0] da; logic [31:0] dwd; logic [3:0] dm;
    bit e_ifr; bit e_ifv; bit e_dr; bit e_dv; bit e_ren; bit e_wen; logic [31:0] e_addr; logic [3:0] e_mask;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n, if_req, d_req, d_wen;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0] d_mask;
  logic [31:0] mem_rdata[3];
  logic ifr[3], ifv[3], dr[3], dv[3], mren[3], mwen[3];
  logic [31:0] ifd[3], dd[3], maddr[3], mwd[3];
  logic [3:0] mmask[3];
  int nvec = 0, nmis = 0, k = 0;
  int m_end[3];
  bit m_own[3], m_last[3], m_store[3];
  logic [31:0] m_addr[3];
  bit hv[3][64];
  logic [31:0] ha[3][64];
  vec_t tbl[18];
  initial forever #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(.LATENCY(LATS[g])) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ready(ifr[g]), .o_if_valid(ifv[g]), .o_if_rdata(ifd[g]),
      .i_d_req(d_req), .i_d_wen(d_wen), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_mask(d_mask),
      .o_d_ready(dr[g]), .o_d_valid(dv[g]), .o_d_rdata(dd[g]),
      .o_mem_addr(maddr[g]), .o_mem_ren(mren[g]), .o_mem_wen(mwen[g]), .o_mem_wdata(mwd[g]), .o_mem_mask(mmask[g]),
      .i_mem_rdata(mem_rdata[g])
    );
  end
  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic out_t actual(input int i);
    return '{ifr[i], ifv[i], ifd[i], dr[i], dv[i], dd[i], maddr[i], mren[i], mwen[i], mwd[i], mmask[i]};
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, k, got, exp);
    end
  endtask
  // Transaction-level reference: a granted request occupies cycles issue..issue+LAT, responding in the last one
  task automatic model(input int i, output out_t e);
    bit win;
    e = '0;
    if (!rst_n) begin
      m_end[i] = -1;
      m_last[i] = 1'b1;
    end else if (k <= m_end[i]) begin
      if (k == m_end[i] && m_own[i]) begin
        e.dv = 1'b1;
        e.dd = m_store[i] ? 32'h0 : memword(m_addr[i]);
      end else if (k == m_end[i]) begin
        e.ifv = 1'b1;
        e.ifd = memword(m_addr[i]);
      end
    end else if (if_req || d_req) begin
      win = d_req && (!if_req || !m_last[i]);
      m_end[i] = k + LATS[i];
      m_own[i] = win;
      m_last[i] = win;
      m_store[i] = win && d_wen;
      m_addr[i] = (win ? d_addr : if_addr) & ~32'h3;
      e.ifr = !win;
      e.dr = win;
      e.ma = m_addr[i];
      e.ren = !(win && d_wen);
      e.wen = win && d_wen;
      e.wd = win ? d_wdata : 32'h0;
      e.mk = win ? d_mask : 4'hF;
    end
  endtask
  task automatic cycle(input bit r, input bit fr, input logic [31:0] fa, input bit dq, input bit dw,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dm);
    out_t e, a;
    @(posedge clk);
    #1;
    k++;
    rst_n = r; if_req = fr; if_addr = fa; d_req = dq; d_wen = dw; d_addr = da; d_wdata = dwd; d_mask = dm;
    for (int i = 0; i < 3; i++)
      mem_rdata[i] = (k >= LATS[i] && hv[i][(k - LATS[i]) % 64]) ? memword(ha[i][(k - LATS[i]) % 64]) : (32'hBAD0_0000 ^ k);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      model(i, e);
      a = actual(i);
      nvec++;
      if (a !== e) begin
        nmis++;
        $display("FAIL model lat=%0d cyc=%0d got=%h exp=%h", LATS[i], k, a, e);
      end
      hv[i][k % 64] = mren[i];
      ha[i][k % 64] = maddr[i];
    end
  endtask
  task automatic idle(input bit r);
    cycle(r, N, 32'h0, N, N, 32'h0, 32'h0, 4'h0);
  endtask
  initial begin
    int n;
    bit seen;
    rst_n = 1'b1; if_req = 0; d_req = 0; d_wen = 0; if_addr = 0; d_addr = 0; d_wdata = 0; d_mask = 0;
    for (int i = 0; i < 3; i++) begin
      mem_rdata[i] = 32'h0;
      m_end[i] = -1;
      m_last[i] = 1'b1;
    end
    #2 rst_n = 1'b0;
    tbl[0]  = '{N, N, 32'h0,  N, N, 32'h0,    32'h0,         4'h0, N, N, N, N, N, N, 32'h0,    4'h0};
    tbl[1]  = '{N, Y, 32'h6,  Y, N, 32'h2005, 32'h0,         4'hF, N, N, N, N, N, N, 32'h0,    4'h0};
    tbl[2]  = '{Y, Y, 32'h6,  Y, N, 32'h2005, 32'h0,         4'hF, Y, N, N, N, Y, N, 32'h4,    4'hF};
    tbl[3]  = '{Y, N, 32'h0,  Y, N, 32'h2005, 32'h0,         4'hF, N, N, N, N, N, N, 32'h0,    4'h0};
    tbl[4]  = '{Y, N, 32'h0,  Y, N, 32'h2005, 32'h0,         4'hF, N, Y, N, N, N, N, 32'h0,    4'h0};
    tbl[5]  = '{Y, N, 32'h0,  Y, N, 32'h2005, 32'h0,         4'hF, N, N, Y, N, Y, N, 32'h2004, 4'hF};
    tbl[6]  = '{Y, Y, 32'h10, Y, N, 32'h30,   32'h0,         4'h3, N, N, N, N, N, N, 32'h0,    4'h0};
    tbl[7]  = '{Y, Y, 32'h10, Y, N, 32'h30,   32'h0,         4'h3, N, N, N, Y, N, N, 32'h0,    4'h0};
    tbl[8]  = '{Y, Y, 32'h10, Y, N, 32'h30,   32'h0,         4'h3, Y, N, N, N, Y, N, 32'h10,   4'hF};
    tbl[9]  = '{Y, N, 32'h0,  Y, N, 32'h30,   32'h0,         4'h3, N, N, N, N, N, N, 32'h0,    4'h0};
    tbl[10] = '{Y, N, 32'h0,  Y, N, 32'h30,   32'h0,         4'h3, N, Y, N, N, N, N, 32'h0,    4'h0};
    tbl[11] = '{Y, N, 32'h0,  Y, N, 32'h30,   32'h0,         4'h3, N, N, Y, N, Y, N, 32'h30,   4'h3};
    tbl[12] = '{Y, N, 32'h0,  N, N, 32'h0,    32'h0,         4'h0, N, N, N, N, N, N, 32'h0,    4'h0};
    tbl[13] = '{Y, N, 32'h0,  N, N, 32'h0,    32'h0,         4'h0, N, N, N, Y, N, N, 32'h0,    4'h0};
    tbl[14] = '{Y, N, 32'h0,  Y, Y, 32'h2003, 32'hAB00_0000, 4'h8, N, N, Y, N, N, Y, 32'h2000, 4'h8};
    tbl[15] = '{Y, N, 32'h0,  N, N, 32'h0,    32'h0,         4'h0, N, N, N, N, N, N, 32'h0,    4'h0};
    tbl[16] = '{Y, N, 32'h0,  N, N, 32'h0,    32'h0,         4'h0, N, N, N, Y, N, N, 32'h0,    4'h0};
    tbl[17] = '{Y, N, 32'h0,  N, N, 32'h0,    32'h0,         4'h0, N, N, N, N, N, N, 32'h0,    4'h0};
    for (int v = 0; v < 18; v++) begin
      cycle(tbl[v].rst, tbl[v].ifr, tbl[v].ia, tbl[v].dr, tbl[v].dw, tbl[v].da, tbl[v].dwd, tbl[v].dm);
      chk($sformatf("table%0d", v), {22'h0, ifr[0], ifv[0], dr[0], dv[0], mren[0], mwen[0], maddr[0], mmask[0]},
          {22'h0, tbl[v].e_ifr, tbl[v].e_ifv, tbl[v].e_dr, tbl[v].e_dv, tbl[v].e_ren, tbl[v].e_wen, tbl[v].e_addr, tbl[v].e_mask});
    end
    idle(N);
    cycle(Y, Y, 32'h40, N, N, 32'h0, 32'h0, 4'h0);
    chk("rst_issue", {63'h0, ifr[0]}, 64'h1);
    idle(N);
    chk("rst_outputs_zero", {26'h0, actual(0) != '0, 37'h0}, 64'h0);
    for (int j = 0; j < 3; j++) begin
      idle(Y);
      chk("rst_no_valid", {62'h0, ifv[0], dv[0]}, 64'h0);
    end
    cycle(Y, Y, 32'h44, N, N, 32'h0, 32'h0, 4'h0);
    chk("rst_reissue", {31'h0, ifr[0], maddr[0]}, {31'h0, 1'b1, 32'h44});
    idle(N);
    for (int j = 0; j < 6; j++) begin
      cycle(Y, Y, 32'h80, N, N, 32'h0, 32'h0, 4'h0);
      chk($sformatf("lat1_stream%0d", j), {62'h0, ifr[1], ifv[1]}, {62'h0, j % 2 == 0, j % 2 == 1});
    end
    idle(N);
    cycle(Y, N, 32'h0, Y, N, 32'h300, 32'h0, 4'hF);
    chk("lat15_issue", {63'h0, dr[2]}, 64'h1);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      idle(Y);
      n++;
      seen = dv[2];
    end
    chk("lat15_resp_delay", 64'(seen ? n : -1), 64'd15);
    for (int j = 0; j < 3000; j++)
      cycle($urandom_range(99) != 0, $urandom_range(2) != 0, $urandom, $urandom_range(2) != 0,
            $urandom_range(1) != 0, $urandom, $urandom, 4'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported unified memory between the hart's instruction-fetch port and its data (load/store) port. Each side issues a request and waits for it to be accepted. The arbiter grants one transaction at a time and tracks the memory's fixed read latency with a counter, then routes the response back to the winning side. It sits between the fetch/memory pipeline stages and the memory model, replacing the separate imem/dmem ports.

## Interface
Parameters:
- LATENCY, default 2: cycles from issue to response; legal range 1–15.

Ports:
- i_clk  in  1  sole clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_if_req  in  1  fetch request; held stable until accepted.
- i_if_addr  in  32  fetch byte address.
- o_if_ready  out  1  fetch request accepted this cycle.
- o_if_valid  out  1  fetch response cycle.
- o_if_rdata  out  32  instruction word; valid when o_if_valid is high.
- i_d_req  in  1  data request; held stable until accepted.
- i_d_wen  in  1  1 = store, 0 = load.
- i_d_addr  in  32  data byte address.
- i_d_wdata  in  32  store data, already lane-shifted.
- i_d_mask  in  4  byte-lane mask.
- o_d_ready  out  1  data request accepted this cycle.
- o_d_valid  out  1  data response cycle (loads and stores).
- o_d_rdata  out  32  load word; 0 for stores.
- o_mem_addr  out  32  word-aligned address (bits [1:0] = 0).
- o_mem_ren / o_mem_wen  out  1 each  one-cycle strobes; never both high.
- o_mem_wdata  out  32  store data.
- o_mem_mask  out  4  lane mask; 4'b1111 for fetch.
- i_mem_rdata  in  32  read data, valid exactly LATENCY cycles after o_mem_ren.

## Operation
- FSM states:
  - IDLE: accepts requests.
  - WAIT: counter cnt runs.
- IDLE with at least one request:
  - Grant one side. Assert its ready and drive the o_mem_* signals combinationally from it (the issue cycle).
  - Load owner and cnt = 1, then go to WAIT.
- IDLE with no request: all o_mem_* are 0; both ready signals are 0.
- Arbitration is round-robin on the last_grant register:
  - When both request, the side not granted last wins.
  - last_grant resets to DATA, so fetch wins the first contention.
- WAIT:
  - Both ready signals are 0 and all o_mem_* are 0.
  - cnt increments each cycle.
  - When cnt == LATENCY: assert the owner's valid (the response cycle) and return to IDLE on the next edge.
- Response data:
  - o_if_rdata = i_mem_rdata in the fetch response cycle, else 0.
  - o_d_rdata = i_mem_rdata for a load response, else 0.
- A request that deasserts before it is accepted is dropped. No error is flagged.
- cnt is 4 bits wide, so LATENCY must be ≤ 15.

## Timing
- Issue at cycle t gives the response at cycle t+LATENCY. The next issue is possible at cycle t+LATENCY+1.
- Throughput: one transaction per LATENCY+1 cycles.
- ready and valid are never high in the same cycle. No back-to-back issue happens from the response cycle.
- A request arriving during WAIT waits; it is evaluated in the first IDLE cycle.
- Reset:
  - Asynchronous assertion forces state = IDLE, cnt = 0, owner = FETCH, last_grant = DATA.
  - All outputs are 0 immediately.
  - An in-flight response is discarded: no valid is emitted after reset.
  - Deassertion takes effect at the next rising edge.

## Structure
- Shared package mem_arb_pkg holds:
  - state encoding localparams: ST_IDLE = 1'b0, ST_WAIT = 1'b1;
  - owner encoding: OWN_FETCH = 1'b0, OWN_DATA = 1'b1;
  - counter width CNT_W = 4.
- Sub-module mem_arb_timer: the loadable latency counter. It takes a start pulse and outputs done when cnt == LATENCY. The FSM and mux remain in mem_arbiter.

## Test plan
1. LATENCY=2, fetch only, addr 0x00000006 → o_if_ready at t; o_mem_addr 0x00000004, mask 1111; o_if_valid at t+2 with rdata = memory word.
2. Both request simultaneously after reset → fetch granted first, data granted at t+3. Repeat the contention → grants alternate.
3. Store at 0x00002003, mask 1000, wdata 0xAB000000 → o_mem_wen one cycle, addr 0x00002000; o_d_valid at t+2 with o_d_rdata = 0.
4. LATENCY=1, continuous fetch requests → accepts at cycles 0, 2, 4; ready and valid never both high.
5. Assert i_rst_n=0 mid-WAIT (cnt=1) → outputs 0 immediately; no valid after release; the next request is issued normally.
6. LATENCY=15, load → response exactly 15 cycles after issue; the counter does not wrap.
